// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, per-cycle actions
// and the packed set of stage enable/flush controls.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} pipe_state_t;

   typedef enum logic [1:0] {IDLE, STALL, FLUSH, FREEZE} pipe_action_t;

   localparam logic [4:0] XZR = 5'd31;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_flush;
      logic exmem_en;
      logic exmem_flush;
      logic memwb_flush;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_IDLE = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                        idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1,
                                        exmem_flush: 1'b0, memwb_flush: 1'b0};

   // Every enable dropped, only the MEM/WB bubble inserted.
   localparam pipe_ctrl_t CTRL_HALT = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                        idex_en: 1'b0, idex_flush: 1'b0, exmem_en: 1'b0,
                                        exmem_flush: 1'b0, memwb_flush: 1'b1};

   function automatic pipe_ctrl_t action_ctrl(input pipe_action_t a);
      pipe_ctrl_t c;
      c = CTRL_IDLE;
      case (a)
         STALL: begin
            c.pc_en      = 1'b0;
            c.ifid_en    = 1'b0;
            c.idex_flush = 1'b1;
         end
         FLUSH: begin
            c.ifid_flush  = 1'b1;
            c.idex_flush  = 1'b1;
            c.exmem_flush = 1'b1;
         end
         FREEZE:  c = CTRL_HALT;
         default: c = CTRL_IDLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: stage status in, stage enables/flushes and perf counters out.
// The pipeline side uses the master modport, the controller the slave modport.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_ra1;
   logic [4:0]       id_ra2;
   logic             ex_memread;
   logic [4:0]       ex_rd;
   logic             mem_branch_taken;
   logic             mem_memread;
   logic             mem_memwrite;
   logic             dmem_ready;

   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_en;
   logic             idex_flush;
   logic             exmem_en;
   logic             exmem_flush;
   logic             memwb_flush;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_valid, id_ra1, id_ra2, ex_memread, ex_rd,
             mem_branch_taken, mem_memread, mem_memwrite, dmem_ready,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, exmem_flush, memwb_flush, mem_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_ra1, id_ra2, ex_memread, ex_rd,
             mem_branch_taken, mem_memread, mem_memwrite, dmem_ready,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, exmem_flush, memwb_flush, mem_err, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments by one on inc, holds at all-ones, never wraps.
// Result is registered (one-cycle latency); there is no backpressure.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; controls are combinational (zero latency).
// A pending data-memory access freezes the pipe; a wait longer than TIMEOUT latches a sticky error.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input logic                   clk,
   input logic                   reset,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

   pipe_state_t       state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic         mem_pend;
   logic         load_use;
   pipe_action_t action;
   pipe_ctrl_t   ctrl;
   logic         stall_inc;
   logic         flush_inc;

   assign mem_pend = (hz.mem_memread | hz.mem_memwrite) & ~hz.dmem_ready;
   assign load_use = hz.id_valid & hz.ex_memread & (hz.ex_rd != XZR) &
                     ((hz.id_ra1 == hz.ex_rd) | (hz.id_ra2 == hz.ex_rd));

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      action     = IDLE;
      ctrl       = CTRL_IDLE;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;

      // Freeze outranks the branch: the branch re-resolves once MEM resumes.
      if (mem_pend) begin
         action = FREEZE;
      end else if (hz.mem_branch_taken) begin
         action = FLUSH;
      end else if (load_use) begin
         action = STALL;
      end

      case (state_q)
         RUN: begin
            if (mem_pend) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (hz.dmem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == TIMEOUT_W) begin
               state_d = ERROR;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase

      if (reset) begin
         ctrl = CTRL_IDLE;
      end else if (state_q == ERROR) begin
         ctrl = CTRL_HALT;
      end else begin
         ctrl      = action_ctrl(action);
         stall_inc = (action == STALL) || (action == FREEZE);
         flush_inc = (action == FLUSH);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .q     (hz.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc),
      .q     (hz.flush_cnt)
   );

   assign hz.pc_en       = ctrl.pc_en;
   assign hz.ifid_en     = ctrl.ifid_en;
   assign hz.ifid_flush  = ctrl.ifid_flush;
   assign hz.idex_en     = ctrl.idex_en;
   assign hz.idex_flush  = ctrl.idex_flush;
   assign hz.exmem_en    = ctrl.exmem_en;
   assign hz.exmem_flush = ctrl.exmem_flush;
   assign hz.memwb_flush = ctrl.memwb_flush;
   assign hz.mem_err     = (state_q == ERROR) & ~reset;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=3): expectations queued
// as each cycle's stimulus is driven, popped and compared at the falling edge.
module tb_pipeline_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 3;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush}
   localparam logic [7:0] C_IDLE   = 8'b1101_0100;
   localparam logic [7:0] C_STALL  = 8'b0001_1100;
   localparam logic [7:0] C_FLUSH  = 8'b1111_1110;
   localparam logic [7:0] C_FREEZE = 8'b0000_0001;

   typedef struct {
      string      tag;
      logic [7:0] ctrl;
      int         stall;
      int         flush;
      logic       err;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic set_in(input logic v, input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic exmr, input logic [4:0] rd, input logic br,
                         input logic mr, input logic mw, input logic rdy);
      hz.id_valid         = v;
      hz.id_ra1           = ra1;
      hz.id_ra2           = ra2;
      hz.ex_memread       = exmr;
      hz.ex_rd            = rd;
      hz.mem_branch_taken = br;
      hz.mem_memread      = mr;
      hz.mem_memwrite     = mw;
      hz.dmem_ready       = rdy;
   endtask

   task automatic zero_in();
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Queue the expectation for the inputs just driven, compare mid-cycle, then clock.
   task automatic cycle(input string tag, input logic [7:0] ctrl, input int stall,
                        input int flush, input logic err);
      exp_t e;
      exp_t p;
      e.tag = tag; e.ctrl = ctrl; e.stall = stall; e.flush = flush; e.err = err;
      sb.push_back(e);
      @(negedge clk);
      p = sb.pop_front();
      check({p.tag, "_ctrl"}, 32'({hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en,
                                   hz.idex_flush, hz.exmem_en, hz.exmem_flush,
                                   hz.memwb_flush}), 32'(p.ctrl));
      check({p.tag, "_stall_cnt"}, 32'(hz.stall_cnt), 32'(p.stall));
      check({p.tag, "_flush_cnt"}, 32'(hz.flush_cnt), 32'(p.flush));
      check({p.tag, "_mem_err"}, 32'(hz.mem_err), 32'(p.err));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      zero_in();
      @(posedge clk);
      #1;

      // Reset forces idle controls even with a pending access.
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle("rst_idle", C_IDLE, 0, 0, 1'b0);
      check("rst_state", 32'(dut.state_q), 32'(RUN));
      check("rst_wait", 32'(dut.wait_cnt_q), 32'd0);
      reset = 1'b0;
      zero_in();
      cycle("idle", C_IDLE, 0, 0, 1'b0);

      // Load-use hazards.
      set_in(1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("lu_ra1", C_STALL, 0, 0, 1'b0);
      zero_in();
      cycle("lu_ra1_after", C_IDLE, 1, 0, 1'b0);
      set_in(1'b1, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("lu_ra2", C_STALL, 1, 0, 1'b0);
      zero_in();
      cycle("lu_ra2_after", C_IDLE, 2, 0, 1'b0);
      set_in(1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("lu_xzr", C_IDLE, 2, 0, 1'b0);
      set_in(1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("lu_novalid", C_IDLE, 2, 0, 1'b0);
      set_in(1'b1, 5'd4, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("lu_nomatch", C_IDLE, 2, 0, 1'b0);
      set_in(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("lu_noload", C_IDLE, 2, 0, 1'b0);

      // Taken branch beats a simultaneous load-use.
      set_in(1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("br_lu", C_FLUSH, 2, 0, 1'b0);
      zero_in();
      cycle("br_after", C_IDLE, 2, 1, 1'b0);

      reset = 1'b1;
      cycle("rst2", C_IDLE, 2, 1, 1'b0);
      reset = 1'b0;
      cycle("rst2_clr", C_IDLE, 0, 0, 1'b0);

      // Memory wait: 3 frozen cycles (branch ignored), then ready.
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle("mw_freeze", C_FREEZE, i, 0, 1'b0);
      check("mw_state", 32'(dut.state_q), 32'(MEM_WAIT));
      check("mw_wait", 32'(dut.wait_cnt_q), 32'd3);
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      cycle("mw_ready", C_IDLE, 3, 0, 1'b0);
      check("mw_ready_state", 32'(dut.state_q), 32'(RUN));
      check("mw_ready_wait", 32'(dut.wait_cnt_q), 32'd0);
      zero_in();
      cycle("mw_done", C_IDLE, 3, 0, 1'b0);

      reset = 1'b1;
      cycle("rst3", C_IDLE, 3, 0, 1'b0);
      reset = 1'b0;

      // Timeout: 5 frozen cycles, then sticky ERROR.
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle("to_freeze", C_FREEZE, i, 0, 1'b0);
      check("to_state", 32'(dut.state_q), 32'(ERROR));
      cycle("to_err", C_FREEZE, 5, 0, 1'b1);
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      cycle("to_sticky", C_FREEZE, 5, 0, 1'b1);
      set_in(1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle("to_sticky_br", C_FREEZE, 5, 0, 1'b1);
      reset = 1'b1;
      cycle("to_rst", C_IDLE, 5, 0, 1'b0);
      reset = 1'b0;
      zero_in();
      cycle("to_clr", C_IDLE, 0, 0, 1'b0);
      check("to_clr_state", 32'(dut.state_q), 32'(RUN));

      // Flush counter saturates at 7 with CNT_W=3.
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle("sat", C_FLUSH, 0, (i < 7) ? i : 7, 1'b0);
      zero_in();
      cycle("sat_end", C_IDLE, 0, 7, 1'b0);

      reset = 1'b1;
      cycle("rmw_rst0", C_IDLE, 0, 7, 1'b0);
      reset = 1'b0;

      // Reset during the second waiting cycle.
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle("rmw_c1", C_FREEZE, 0, 0, 1'b0);
      check("rmw_c1_state", 32'(dut.state_q), 32'(MEM_WAIT));
      check("rmw_c1_wait", 32'(dut.wait_cnt_q), 32'd1);
      reset = 1'b1;
      cycle("rmw_rst", C_IDLE, 1, 0, 1'b0);
      reset = 1'b0;
      check("rmw_state", 32'(dut.state_q), 32'(RUN));
      check("rmw_wait", 32'(dut.wait_cnt_q), 32'd0);
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      cycle("rmw_after", C_IDLE, 0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
